// File: rtl/ecc_secded_pkg.sv
// Shared constants, types and the Hamming check-bit function for the 64x8 SECDED decoder.
// Latency: none (package only).
// Backpressure: not applicable.
package ecc_secded_pkg;

  localparam int DATA_W = 64;
  localparam int CHK_W  = 8;
  localparam int HAM_W  = 7;
  localparam int CW_LEN = 71;

  // Codeword position (1..71) of each data bit.
  typedef logic [DATA_W-1:0][HAM_W-1:0] pos_tbl_t;
  // For each Hamming check bit, the set of data bits it covers.
  typedef logic [HAM_W-1:0][DATA_W-1:0] mask_tbl_t;

  // Word entering the decode stage.
  typedef struct packed {
    logic              vld;
    logic              correct_n;
    logic [DATA_W-1:0] dat;
    logic [CHK_W-1:0]  chk;
  } in_word_t;

  // Registered result presented on the output ports.
  typedef struct packed {
    logic              vld;
    logic              sbit;
    logic              dbit;
    logic [CHK_W-1:0]  syn;
    logic [DATA_W-1:0] dat;
  } out_word_t;

  // Data bits occupy the non-power-of-two positions in ascending order.
  function automatic pos_tbl_t build_pos_table();
    pos_tbl_t t;
    int       k;
    t = '0;
    k = 0;
    for (int p = 1; p <= CW_LEN; p++) begin
      if ((p & (p - 1)) != 0) begin
        t[k] = p[HAM_W-1:0];
        k++;
      end
    end
    return t;
  endfunction

  localparam pos_tbl_t DATA_POS = build_pos_table();

  // Check bit j covers every data bit whose position has bit j set.
  function automatic mask_tbl_t build_chk_mask();
    mask_tbl_t m;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      for (int j = 0; j < HAM_W; j++) begin
        m[j][i] = DATA_POS[i][j];
      end
    end
    return m;
  endfunction

  localparam mask_tbl_t CHK_MASK = build_chk_mask();

  // The 7 Hamming check bits an encoder would produce for this data word.
  function automatic logic [HAM_W-1:0] calc_chk7(input logic [DATA_W-1:0] data);
    logic [HAM_W-1:0] c;
    for (int j = 0; j < HAM_W; j++) begin
      c[j] = ^(data & CHK_MASK[j]);
    end
    return c;
  endfunction

endpackage

// File: rtl/ecc_secded_syndrome.sv
// Syndrome, overall parity and one-hot data flip mask for one received 72-bit word.
// Latency: combinational.
// Backpressure: none; evaluates whatever is presented.
module ecc_secded_syndrome
  import ecc_secded_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [CHK_W-1:0]  chk,
  output logic [HAM_W-1:0]  syn,
  output logic              par,
  output logic [DATA_W-1:0] flip_mask
);

  // The mask only hits when the syndrome names a data position; check-bit
  // positions and out-of-range syndromes leave it all-zero.
  always_comb begin
    syn       = calc_chk7(data) ^ chk[HAM_W-1:0];
    par       = ^{data, chk};
    flip_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      flip_mask[i] = (syn == DATA_POS[i]);
    end
  end

endmodule

// File: rtl/ecc_secded_dec_64x8.sv
// SECDED read-side decoder: corrects single-bit errors, flags uncorrectable ones, counts both.
// Latency: 2 cycles with C_REG_INPUT=1, 1 cycle with C_REG_INPUT=0 (enabled cycles only).
// Backpressure: none; one word per enabled cycle. ECC_ERR_CNT_EN enables the error counters.
module ecc_secded_dec_64x8
  import ecc_secded_pkg::*;
#(
  parameter int C_REG_INPUT = 1,
  parameter int C_CNT_WIDTH = 16
) (
  input  logic                   ecc_clk,
  input  logic                   ecc_reset,
  input  logic                   ecc_clken,
  input  logic                   ecc_valid_in,
  input  logic [DATA_W-1:0]      ecc_data_in,
  input  logic [CHK_W-1:0]       ecc_chkbits_in,
  input  logic                   ecc_correct_n,
  output logic                   ecc_valid_out,
  output logic [DATA_W-1:0]      ecc_data_out,
  output logic                   ecc_sbit_err,
  output logic                   ecc_dbit_err,
  output logic [CHK_W-1:0]       ecc_err_syndrome,
  input  logic                   ecc_cnt_clr,
  output logic [C_CNT_WIDTH-1:0] ecc_sbit_cnt,
  output logic [C_CNT_WIDTH-1:0] ecc_dbit_cnt
);

  in_word_t  in_cur;
  in_word_t  in_q;
  out_word_t out_nxt;
  out_word_t out_q;

  logic [HAM_W-1:0]  syn;
  logic              par;
  logic [DATA_W-1:0] flip_mask;
  logic              syn_in_range;

  assign in_cur = {ecc_valid_in, ecc_correct_n, ecc_data_in, ecc_chkbits_in};

  generate
    if (C_REG_INPUT != 0) begin : g_in_reg
      // Input stage; correct_n travels with its word so mode changes line up with data.
      always_ff @(posedge ecc_clk) begin
        if (ecc_reset) begin
          in_q <= '0;
        end else if (ecc_clken) begin
          in_q <= in_cur;
        end
      end
    end else begin : g_in_bypass
      assign in_q = in_cur;
    end
  endgenerate

  ecc_secded_syndrome u_syndrome (
    .data      (in_q.dat),
    .chk       (in_q.chk),
    .syn       (syn),
    .par       (par),
    .flip_mask (flip_mask)
  );

  assign syn_in_range = (syn <= 7'(CW_LEN));

  // Classify and correct. Odd parity with an in-range syndrome is a single error
  // (s=0 means chkbits[7], a power of two means a Hamming check bit); anything
  // else non-clean is uncorrectable. Flags are suppressed for invalid words.
  always_comb begin
    out_nxt      = '0;
    out_nxt.vld  = in_q.vld;
    out_nxt.sbit = in_q.vld & par & syn_in_range;
    out_nxt.dbit = in_q.vld & ((par & ~syn_in_range) | (~par & (syn != '0)));
    out_nxt.syn  = {par, syn};
    out_nxt.dat  = in_q.dat ^ (flip_mask & {DATA_W{par & ~in_q.correct_n}});
  end

  // Output stage; reset overrides the clock enable so an in-flight word is dropped.
  always_ff @(posedge ecc_clk) begin
    if (ecc_reset) begin
      out_q <= '0;
    end else if (ecc_clken) begin
      out_q <= out_nxt;
    end
  end

  assign ecc_valid_out    = out_q.vld;
  assign ecc_data_out     = out_q.dat;
  assign ecc_sbit_err     = out_q.sbit;
  assign ecc_dbit_err     = out_q.dbit;
  assign ecc_err_syndrome = out_q.syn;

`ifdef ECC_ERR_CNT_EN
  logic [C_CNT_WIDTH-1:0] sbit_cnt;
  logic [C_CNT_WIDTH-1:0] dbit_cnt;
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

  // Saturating counters bumped as each flagged word is loaded into the output
  // stage; clear beats a same-cycle increment and works even with clken low.
  always_ff @(posedge ecc_clk) begin
    if (ecc_reset || ecc_cnt_clr) begin
      sbit_cnt <= '0;
      dbit_cnt <= '0;
    end else if (ecc_clken) begin
      if (out_nxt.sbit && (sbit_cnt != '1)) begin
        sbit_cnt <= sbit_cnt + CNT_ONE;
      end
      if (out_nxt.dbit && (dbit_cnt != '1)) begin
        dbit_cnt <= dbit_cnt + CNT_ONE;
      end
    end
  end

  assign ecc_sbit_cnt = sbit_cnt;
  assign ecc_dbit_cnt = dbit_cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = ecc_cnt_clr;
  assign ecc_sbit_cnt   = '0;
  assign ecc_dbit_cnt   = '0;
`endif

endmodule
